data_mem_dump_arbiter: RTL

- Shares the single data-memory port between the pipeline MEM stage and the debug unit's memory-dump sequencer.
- Pipeline always has priority while en_pipeline is high.
- On dump_start_i (pipeline halted), the block walks every data-memory word from address 0 to DEPTH-1 and streams each word out on a valid/ready interface to the debug UART TX path.
- Sits between mem-stage control and the data memory's enable/addr/read/write inputs.

---
 rtl/data_mem_dump_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/data_mem_dump_arbiter.sv
// Data-memory port arbiter: the pipeline MEM stage owns the port whenever
// en_pipeline is high; otherwise a dump sequencer walks addresses
// 0..DEPTH-1 and streams each word out over a valid/ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no dump running; a latched start request waits for the port
// ST_ISSUE | read strobe for counter address (stalls while pipeline owns port)
// ST_WAIT  | registered memory data arrives, captured into the output word
// ST_HOLD  | word presented on dump_valid_o until the consumer accepts it
// ST_DONE  | one-cycle completion pulse after the last word is accepted
module data_mem_dump_arbiter #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 7,
   parameter int DEPTH   = 128
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               en_pipeline,
   input  logic [NB_ADDR-1:0] pipe_addr_i,
   input  logic               pipe_mem_read_i,
   input  logic               pipe_mem_write_i,
   input  logic               dump_start_i,
   input  logic               dump_ready_i,
   input  logic [NB_DATA-1:0] mem_data_i,
   output logic               mem_enable_o,
   output logic [NB_ADDR-1:0] mem_addr_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   output logic [NB_DATA-1:0] dump_word_o,
   output logic [NB_ADDR-1:0] dump_addr_o,
   output logic               dump_valid_o,
   output logic               dump_busy_o,
   output logic               dump_done_o
);

   localparam int NB_CNT = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [NB_CNT-1:0] LAST_IDX = NB_CNT'(DEPTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_HOLD,
      ST_DONE
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                pending;
   logic [NB_CNT-1:0]   counter;
   logic [NB_ADDR-1:0]  counter_addr;
   logic                accept;

   assign accept       = dump_valid_o & dump_ready_i;
   assign counter_addr = NB_ADDR'(counter);

   // state register
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // next-state logic; only ISSUE yields to the pipeline, later states
   // finish their word regardless of who owns the memory port
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (pending && !en_pipeline) state_nxt = ST_ISSUE;
         ST_ISSUE: if (!en_pipeline)            state_nxt = ST_WAIT;
         ST_WAIT:  state_nxt = ST_HOLD;
         ST_HOLD:  if (accept) state_nxt = (counter == LAST_IDX) ? ST_DONE : ST_ISSUE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // memory port mux and status outputs; the dump path never writes memory
   always_comb begin
      mem_enable_o = 1'b0;
      mem_addr_o   = '0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      if (en_pipeline) begin
         mem_enable_o = 1'b1;
         mem_addr_o   = pipe_addr_i;
         mem_read_o   = pipe_mem_read_i;
         mem_write_o  = pipe_mem_write_i;
      end else if (state == ST_ISSUE) begin
         mem_enable_o = 1'b1;
         mem_addr_o   = counter_addr;
         mem_read_o   = 1'b1;
      end
      dump_busy_o = pending | (state != ST_IDLE);
      dump_done_o = (state == ST_DONE);
   end

   // start-request latch; clearing on ISSUE entry wins over a held start
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         pending <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (state_nxt == ST_ISSUE) pending <= 1'b0;
         else if (dump_start_i)     pending <= 1'b1;
      end
   end

   // word index; parked at zero in IDLE so every dump starts from address 0
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         counter <= '0;
      end else if (state == ST_IDLE) begin
         counter <= '0;
      end else if (state == ST_HOLD && accept && counter != LAST_IDX) begin
         counter <= counter + 1'b1;
      end
   end

   // output word register: capture in WAIT, release on handshake
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         dump_word_o  <= '0;
         dump_addr_o  <= '0;
         dump_valid_o <= 1'b0;
      end else if (state == ST_WAIT) begin
         dump_word_o  <= mem_data_i;
         dump_addr_o  <= counter_addr;
         dump_valid_o <= 1'b1;
      end else if (state == ST_HOLD && accept) begin
         dump_valid_o <= 1'b0;
      end
   end

endmodule
